// File: rtl/ascon_stream_out.sv
// ascon_stream_out: buffers ciphertext/tag blocks and streams them as 32-bit words, MSW first.
module ascon_stream_out #(
  parameter int DEPTH = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [4:0][63:0] state_i,
  input  logic [127:0]     key_i,
  input  logic             en_cipher_i,
  input  logic             en_tag_i,
  output logic [31:0]      word_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             is_tag_o,
  output logic             last_o,
  output logic             full_o,
  output logic             err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t st;
  logic [128:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count, count_nxt;
  logic [1:0] idx;
  logic [128:0] entry, cur;
  logic push_req, push_ok, hs, pop;
  assign push_req = en_cipher_i | en_tag_i;
  assign hs = valid_o & ready_i;
  assign pop = hs & (&idx);
  // A full FIFO still accepts a push when its head is popped in the same cycle.
  assign push_ok = push_req & (~full_o | pop);
  assign entry = en_tag_i ? {1'b1, {state_i[3], state_i[4]} ^ key_i} : {1'b0, state_i[0], state_i[1]};
  assign count_nxt = count + PW'(push_ok) - PW'(pop);
  assign cur = mem[rd_ptr[AW-1:0]];
  assign valid_o = st == STREAM;
  assign word_o = valid_o ? cur[{~idx, 5'd0} +: 32] : '0;
  assign is_tag_o = valid_o & cur[128];
  assign last_o = is_tag_o & (&idx);
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      idx <= '0;
      full_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= entry;
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (hs) idx <= idx + 2'd1;
      count <= count_nxt;
      full_o <= count_nxt == PW'(DEPTH);
      err_o <= err_o | (en_cipher_i & en_tag_i) | (push_req & ~push_ok);
      st <= (count_nxt != '0) ? STREAM : IDLE;
    end
  end
endmodule

// File: tb/tb_ascon_stream_out.sv
// tb_ascon_stream_out: directed test-plan vectors plus random traffic against a queue model.
module tb_ascon_stream_out;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 0, en_c = 0, en_t = 0, rdy = 0;
  logic [4:0][63:0] state = '0;
  logic [127:0] key = '0;
  logic [31:0] word;
  logic valid, is_tag, last, full, err;
  int checks = 0, errors = 0;
  bit started = 0;
  logic [128:0] q[$];
  int idx = 0;
  logic merr = 0;

  ascon_stream_out #(.DEPTH(DEPTH)) dut (
    .clock_i(clk), .reset_i(rst), .state_i(state), .key_i(key),
    .en_cipher_i(en_c), .en_tag_i(en_t), .word_o(word), .valid_o(valid),
    .ready_i(rdy), .is_tag_o(is_tag), .last_o(last), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic mv, pop, acc;
    logic [128:0] e;
    if (rst) begin
      q.delete();
      idx <= 0;
      merr <= 0;
    end else begin
      mv = q.size() > 0;
      pop = mv && rdy && idx == 3;
      acc = 0;
      e = en_t ? {1'b1, {state[3], state[4]} ^ key} : {1'b0, state[0], state[1]};
      if (mv && rdy) idx <= (idx + 1) % 4;
      if (en_c && en_t) merr <= 1;
      if (en_c || en_t) begin
        if (q.size() < DEPTH || pop) acc = 1;
        else merr <= 1;
      end
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  end

  always @(negedge clk) begin : compare
    logic [128:0] h;
    if (started) begin
      chk("valid", 32'(valid), 32'(q.size() > 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("err", 32'(err), 32'(merr));
      if (q.size() > 0) begin
        h = q[0];
        chk("word", word, h[(3 - idx) * 32 +: 32]);
        chk("is_tag", 32'(is_tag), 32'(h[128]));
        chk("last", 32'(last), 32'(h[128] && idx == 3));
      end
    end
  end

  task automatic ew(input logic [31:0] w, input logic t, input logic l);
    chk("lit_valid", 32'(valid), 32'd1);
    chk("lit_word", word, w);
    chk("lit_tag", 32'(is_tag), 32'(t));
    chk("lit_last", 32'(last), 32'(l));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic tag_words(input logic l);
    ew(32'h48792FC6, 1, 0);
    ew(32'h9DD244D7, 1, 0);
    ew(32'h4B80C779, 1, 0);
    ew(32'h2DFB8FDB, 1, l);
  endtask

  logic [63:0] a0, a1, b0, b1, c0, c1;

  initial begin
    rst = 1;
    @(negedge clk);
    started = 1;
    rst = 0;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_word", word, 0);
    chk("rst_tag", 32'(is_tag), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    // cipher capture
    state[0] = 64'h82bf91294ba5808d;
    state[1] = 64'hd81eeca694136f8a;
    en_c = 1; rdy = 1;
    @(negedge clk);
    en_c = 0;
    ew(32'h82bf9129, 0, 0); ew(32'h4ba5808d, 0, 0); ew(32'hd81eeca6, 0, 0); ew(32'h94136f8a, 0, 0);
    chk("cipher_done", 32'(valid), 0);
    // tag capture
    key = 128'h691AED630E81901F6CB10AD9CA912F80;
    state[3] = 64'h2163C2A59353D4C8;
    state[4] = 64'h2731CDA0E76AA05B;
    en_t = 1;
    @(negedge clk);
    en_t = 0;
    tag_words(1);
    chk("tag_done", 32'(valid), 0);
    // backpressure
    rdy = 0; en_c = 1;
    @(negedge clk);
    en_c = 0;
    repeat (5) ew(32'h82bf9129, 0, 0);
    rdy = 1;
    ew(32'h82bf9129, 0, 0); ew(32'h4ba5808d, 0, 0); ew(32'hd81eeca6, 0, 0); ew(32'h94136f8a, 0, 0);
    chk("bp_done", 32'(valid), 0);
    // overflow
    a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
    b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    c0 = {$urandom, $urandom}; c1 = {$urandom, $urandom};
    chk("ovf_err_pre", 32'(err), 0);
    rdy = 0; en_c = 1; state[0] = a0; state[1] = a1;
    @(negedge clk);
    state[0] = b0; state[1] = b1;
    @(negedge clk);
    chk("ovf_full", 32'(full), 1);
    state[0] = c0; state[1] = c1;
    @(negedge clk);
    en_c = 0;
    chk("ovf_err", 32'(err), 1);
    rdy = 1;
    ew(a0[63:32], 0, 0); ew(a0[31:0], 0, 0); ew(a1[63:32], 0, 0); ew(a1[31:0], 0, 0);
    ew(b0[63:32], 0, 0); ew(b0[31:0], 0, 0); ew(b1[63:32], 0, 0); ew(b1[31:0], 0, 0);
    chk("ovf_done", 32'(valid), 0);
    chk("ovf_nfull", 32'(full), 0);
    // simultaneous enables
    do_reset();
    chk("sim_err_pre", 32'(err), 0);
    en_c = 1; en_t = 1;
    @(negedge clk);
    en_c = 0; en_t = 0;
    tag_words(1);
    chk("sim_err", 32'(err), 1);
    chk("sim_done", 32'(valid), 0);
    // reset mid-stream
    do_reset();
    state[0] = a0; state[1] = a1; en_c = 1;
    @(negedge clk);
    en_c = 0;
    ew(a0[63:32], 0, 0); ew(a0[31:0], 0, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_valid", 32'(valid), 0);
    chk("mid_full", 32'(full), 0);
    chk("mid_err", 32'(err), 0);
    state[0] = b0; state[1] = b1; en_c = 1;
    @(negedge clk);
    en_c = 0;
    ew(b0[63:32], 0, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(199) == 0);
      en_c = ($urandom_range(3) == 0);
      en_t = ($urandom_range(5) == 0);
      rdy = ($urandom_range(2) != 0);
      for (int k = 0; k < 5; k++) state[k] = {$urandom, $urandom};
      if ($urandom_range(15) == 0) key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
